miriscv_mdu_seq: RTL and testbench

Multi-cycle sequencer for the M-extension multiply/divide unit in the execute stage. It accepts one MDU request per instruction and runs an iterative shift-add multiply or restoring divide. It holds the pipeline through `stall_req_o` until the result is ready, and aborts cleanly on a pipeline kill. Its port contract matches the execute stage's MDU instance: `req`, operands, `op`, `kill`, `keep`, `result` and `stall_req`.

---
 rtl/miriscv_mdu_seq.sv | 179 +++++++++++++++++
 tb/tb_miriscv_mdu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/miriscv_mdu_seq.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : miriscv_mdu_seq                                               |
// | Purpose  : Multi-cycle sequencer for the RV32M multiply/divide unit.     |
// |            Runs a 32-step shift-add multiply or restoring divide on      |
// |            operand magnitudes, then applies sign correction when the     |
// |            result is read. Divide-by-zero and signed overflow finish     |
// |            without iterating.                                            |
// | Ports    : clk_i, arstn_i (async, active-low)                            |
// |            mdu_req_i, mdu_port_a_i, mdu_port_b_i, mdu_op_i (funct3)      |
// |            mdu_kill_i (abort), mdu_keep_i (hold finished result)         |
// |            mdu_result_o, mdu_stall_req_o                                 |
// | Options  : MIRISCV_MDU_FAST_MUL_EN - single-cycle combinational multiply |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_mdu_seq #(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                mdu_req_i,
  input  logic [XLEN-1:0]     mdu_port_a_i,
  input  logic [XLEN-1:0]     mdu_port_b_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic                mdu_kill_i,
  input  logic                mdu_keep_i,
  output logic [XLEN-1:0]     mdu_result_o,
  output logic                mdu_stall_req_o
);

  localparam logic [MDU_OP_W-1:0] c_op_mul    = MDU_OP_W'(0);
  localparam logic [MDU_OP_W-1:0] c_op_mulh   = MDU_OP_W'(1);
  localparam logic [MDU_OP_W-1:0] c_op_mulhsu = MDU_OP_W'(2);
  localparam logic [MDU_OP_W-1:0] c_op_div    = MDU_OP_W'(4);
  localparam logic [MDU_OP_W-1:0] c_op_divu   = MDU_OP_W'(5);
  localparam logic [XLEN-1:0]     c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [4:0]            r_cnt;
  logic [MDU_OP_W-1:0]   r_op;
  logic [XLEN-1:0]       r_opnd;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     r_acc;     // {hi, lo}: product, or {remainder, quotient}
  logic                  r_neg_q;   // negate product / quotient on readout
  logic                  r_neg_r;   // negate remainder on readout

  // Operand decode: signedness depends on op class
  logic              w_is_mul, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_fast, w_start;

  assign w_is_mul   = ~mdu_op_i[2];
  assign w_a_signed = w_is_mul ? (mdu_op_i == c_op_mulh || mdu_op_i == c_op_mulhsu)
                               : ~mdu_op_i[0];
  assign w_b_signed = w_is_mul ? (mdu_op_i == c_op_mulh) : ~mdu_op_i[0];
  assign w_a_neg    = w_a_signed & mdu_port_a_i[XLEN-1];
  assign w_b_neg    = w_b_signed & mdu_port_b_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~mdu_port_a_i + 1'b1) : mdu_port_a_i;
  assign w_b_mag    = w_b_neg ? (~mdu_port_b_i + 1'b1) : mdu_port_b_i;
  assign w_div_zero = ~w_is_mul & (mdu_port_b_i == '0);
  assign w_div_ovf  = ~w_is_mul & w_a_signed & (mdu_port_a_i == c_int_min) &
                      (mdu_port_b_i == '1);

`ifdef MIRISCV_MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fast_a, w_fast_b;
  logic signed [2*XLEN+1:0] w_fast_prod;
  assign w_fast_a    = {w_a_signed & mdu_port_a_i[XLEN-1], mdu_port_a_i};
  assign w_fast_b    = {w_b_signed & mdu_port_b_i[XLEN-1], mdu_port_b_i};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast      = w_is_mul;
`else
  assign w_fast      = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) & mdu_req_i & ~mdu_kill_i & ~w_fast;

  // One iteration step for each op class
  logic [XLEN:0]     w_mul_sum, w_rem_sh, w_rem_diff;
  logic              w_rem_ge;
  logic [2*XLEN-1:0] w_mul_next, w_div_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_opnd});
  assign w_rem_diff = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = {(w_rem_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_rem_ge};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (mdu_kill_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op    <= mdu_op_i;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div_zero) begin
              // Raw results stored directly, no sign fix-up on readout
              r_acc   <= {mdu_port_a_i, {XLEN{1'b1}}};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else if (w_div_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, c_int_min};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              // Multiply: multiplier shifts out of lo; divide: dividend shifts out of lo
              r_opnd  <= w_is_mul ? w_a_mag : w_b_mag;
              r_acc   <= {{XLEN{1'b0}}, (w_is_mul ? w_b_mag : w_a_mag)};
              r_cnt   <= 5'd31;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!mdu_keep_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sign correction on readout
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    mdu_result_o    = '0;
    mdu_stall_req_o = arstn_i & ~mdu_kill_i &
                      ((r_state == ST_BUSY) | w_start);
    if (arstn_i && !mdu_kill_i) begin
      if (r_state == ST_DONE) begin
        if (!r_op[2])
          mdu_result_o = (r_op == c_op_mul) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else
          mdu_result_o = (r_op == c_op_div || r_op == c_op_divu) ? w_quo : w_rem;
      end
`ifdef MIRISCV_MDU_FAST_MUL_EN
      else if (r_state == ST_IDLE && mdu_req_i && w_is_mul) begin
        mdu_result_o = (mdu_op_i == c_op_mul) ? w_fast_prod[XLEN-1:0]
                                              : w_fast_prod[2*XLEN-1:XLEN];
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_miriscv_mdu_seq.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_miriscv_mdu_seq                                            |
// | Purpose  : Directed self-checking bench for miriscv_mdu_seq. Expected    |
// |            results go into a queue when a request is driven and are      |
// |            popped when the unit releases its stall.                      |
// | Options  : MIRISCV_MDU_FAST_MUL_EN - expect zero-stall multiplies        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_miriscv_mdu_seq;

  localparam int XLEN = 32;

  localparam logic [2:0] c_mul = 3'd0, c_mulh = 3'd1, c_mulhsu = 3'd2, c_mulhu = 3'd3;
  localparam logic [2:0] c_div = 3'd4, c_divu = 3'd5, c_rem = 3'd6, c_remu = 3'd7;

`ifdef MIRISCV_MDU_FAST_MUL_EN
  localparam int c_mul_stalls = 0;
`else
  localparam int c_mul_stalls = 33;
`endif

  logic            clk = 1'b0;
  logic            arstn;
  logic            req, kill, keep;
  logic [XLEN-1:0] a, b;
  logic [2:0]      op;
  logic [XLEN-1:0] result;
  logic            stall;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  miriscv_mdu_seq #(.XLEN(XLEN), .MDU_OP_W(3)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .mdu_req_i       (req),
    .mdu_port_a_i    (a),
    .mdu_port_b_i    (b),
    .mdu_op_i        (op),
    .mdu_kill_i      (kill),
    .mdu_keep_i      (keep),
    .mdu_result_o    (result),
    .mdu_stall_req_o (stall)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one request, wait for the stall to drop, compare result and stall length.
  // With keep_n > 0, keep is held so the result must persist for keep_n extra cycles.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] av,
                        input logic [XLEN-1:0] bv, input logic [XLEN-1:0] expv,
                        input int exp_stalls, input int keep_n);
    int n;
    bit done;
    logic [XLEN-1:0] want;
    @(posedge clk); #1;
    req = 1'b1; op = o; a = av; b = bv; keep = (keep_n > 0);
    exp_q.push_back(expv);
    n = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (stall) begin
        n++;
        if (n == 2) chk({tag, "_busy_res"}, result, '0);
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, {31'd0, stall}, '0);
      void'(exp_q.pop_front());
    end else begin
      want = exp_q.pop_front();
      chk({tag, "_res"}, result, want);
      chk({tag, "_stalls"}, n, exp_stalls);
      for (int i = 0; i < keep_n; i++) begin
        @(posedge clk); #1;
        if (i == keep_n - 1) keep = 1'b0;
        @(negedge clk);
        chk({tag, "_keep_res"}, result, want);
        chk({tag, "_keep_stall"}, {31'd0, stall}, '0);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    req = 1'b0; keep = 1'b0; kill = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    arstn = 1'b0; req = 1'b0; kill = 1'b0; keep = 1'b0;
    a = '0; b = '0; op = '0;
    #12;
    chk("rst_stall", {31'd0, stall}, '0);
    chk("rst_res", result, '0);
    @(posedge clk); #1 arstn = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, '0);
    chk("idle_res", result, '0);

    // Unsigned divide, back-to-back
    run_op("divu_100_7", c_divu, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", c_remu, 32'd100, 32'd7, 32'd2, 33, 0);
    // Signed divide and overflow
    run_op("div_m7_2",   c_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",   c_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("div_ovf",    c_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",    c_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    // Divide by zero
    run_op("divu_5_0",   c_divu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0",   c_remu, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("rem_m5_0",   c_rem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
    idle_cycles(2);
    // Multiplies
    run_op("mulh_m1_m1",  c_mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, c_mul_stalls, 0);
    run_op("mulhu_m1_m1", c_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_mul_stalls, 0);
    run_op("mulhsu_m1_2", c_mulhsu, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, c_mul_stalls, 0);
    run_op("mul_1234_10", c_mul,    32'h1234, 32'h10, 32'h12340, c_mul_stalls, 0);
    run_op("mul_m3_5",    c_mul,    32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, c_mul_stalls, 0);
    idle_cycles(1);

    // Result held under keep
    run_op("keep_divu", c_divu, 32'd100, 32'd7, 32'd14, 33, 3);
    idle_cycles(1);

    // Kill in BUSY cycle 10 of a DIV
    @(posedge clk); #1;
    req = 1'b1; op = c_div; a = 32'hFFFF_FF9C; b = 32'd7;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("kill_pre_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1 kill = 1'b1;
    @(negedge clk);
    chk("kill_stall", {31'd0, stall}, '0);
    chk("kill_res", result, '0);
    @(posedge clk); #1 kill = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_kill_stall", {31'd0, stall}, '0);
    run_op("divu_9_3_after_kill", c_divu, 32'd9, 32'd3, 32'd3, 33, 0);
    idle_cycles(1);

    // Async reset pulse mid-BUSY
    @(posedge clk); #1;
    req = 1'b1; op = c_divu; a = 32'd100; b = 32'd7;
    repeat (5) @(posedge clk);
    #3 arstn = 1'b0; req = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, '0);
    chk("arst_res", result, '0);
    @(posedge clk); #1 arstn = 1'b1;
    run_op("divu_9_3_after_rst", c_divu, 32'd9, 32'd3, 32'd3, 33, 0);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
